// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial receiver: FSM encoding, default sync marker,
// frame checksum step and the saturating 8-bit increment used by the error counters.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic logic [7:0] frame_csum_step(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/serial_frame_receive.sv
// Hunts for a sync byte, collects PAYLOAD_BYTES bytes, verifies an XOR checksum and commits
// the frame to a stable register with a one-cycle payload_valid pulse (1 clk after last byte).
module serial_frame_receive
  import serial_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES  = 64,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter bit          CHECK_EN       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [PAYLOAD_BYTES*8-1:0] payload,
  output logic                       payload_valid,
  output logic                       busy,
  output logic [7:0]                 crc_err_count,
  output logic [7:0]                 timeout_err_count
);

  localparam int W  = PAYLOAD_BYTES * 8;
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e          state_q;
  logic [W-1:0]    buf_q;
  logic [W-1:0]    payload_q;
  logic            payload_valid_q;
  logic [7:0]      csum_q;
  logic [7:0]      crc_err_q;
  logic [7:0]      tmo_err_q;
  logic [CW-1:0]   byte_cnt_q;
  logic [TW-1:0]   timer_q;

  logic [W-1:0]    shifted_d;
  logic [7:0]      csum_d;
  logic            timeout_d;

  // Oldest byte ends up in the MSBs once the whole payload has been shifted in.
  assign shifted_d = W'({buf_q, rx_data});
  assign csum_d    = frame_csum_step(csum_q, rx_data);
  // A byte arriving on the last allowed cycle wins over the timeout.
  assign timeout_d = TMO_EN && (state_q != ST_HUNT) && !rx_valid && (timer_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_HUNT;
      buf_q           <= '0;
      payload_q       <= '0;
      payload_valid_q <= 1'b0;
      csum_q          <= 8'h00;
      crc_err_q       <= 8'h00;
      tmo_err_q       <= 8'h00;
      byte_cnt_q      <= '0;
      timer_q         <= '0;
    end else begin
      payload_valid_q <= 1'b0;
      if (timeout_d) begin
        state_q   <= ST_HUNT;
        tmo_err_q <= sat_inc8(tmo_err_q);
      end else begin
        if (state_q != ST_HUNT) begin
          timer_q <= rx_valid ? '0 : timer_q + 1'b1;
        end
        case (state_q)
          ST_HUNT: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
              state_q    <= ST_PAYLOAD;
              byte_cnt_q <= '0;
              csum_q     <= 8'h00;
              timer_q    <= '0;
            end
          end
          ST_PAYLOAD: begin
            if (rx_valid) begin
              buf_q      <= shifted_d;
              csum_q     <= csum_d;
              byte_cnt_q <= byte_cnt_q + 1'b1;
              if (byte_cnt_q == LAST_IDX) begin
                if (CHECK_EN) begin
                  state_q <= ST_CHECK;
                end else begin
                  payload_q       <= shifted_d;
                  payload_valid_q <= 1'b1;
                  state_q         <= ST_HUNT;
                end
              end
            end
          end
          ST_CHECK: begin
            if (rx_valid) begin
              if (rx_data == csum_q) begin
                payload_q       <= buf_q;
                payload_valid_q <= 1'b1;
              end else begin
                crc_err_q <= sat_inc8(crc_err_q);
              end
              state_q <= ST_HUNT;
            end
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end

  assign payload           = payload_q;
  assign payload_valid     = payload_valid_q;
  assign busy              = (state_q != ST_HUNT);
  assign crc_err_count     = crc_err_q;
  assign timeout_err_count = tmo_err_q;

endmodule

// File: tb/tb_serial_frame_receive.sv
// Directed bench for serial_frame_receive (4-byte payload, checksum on, 16-cycle timeout);
// committed frames are checked against a queue of expected payloads.
module tb_serial_frame_receive;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] payload;
  logic        payload_valid;
  logic        busy;
  logic [7:0]  crc_err_count;
  logic [7:0]  timeout_err_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic        pv_prev = 1'b0;

  serial_frame_receive #(
    .PAYLOAD_BYTES (4),
    .SYNC_BYTE     (8'hA5),
    .CHECK_EN      (1'b1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .payload          (payload),
    .payload_valid    (payload_valid),
    .busy             (busy),
    .crc_err_count    (crc_err_count),
    .timeout_err_count(timeout_err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every payload_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!reset && payload_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", payload, 32'hxxxx_xxxx);
      end else begin
        check("commit_payload", payload, exp_q.pop_front());
      end
      check("pv_single_cycle", {31'd0, pv_prev}, 32'd0);
    end
    pv_prev = payload_valid;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] p, input logic [7:0] ck, input bit good);
    if (good) exp_q.push_back(p);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(p[31-8*i -: 8]);
    send_byte(ck);
  endtask

  // Bounded wait for the scoreboard to consume all expected commits.
  task automatic expect_drained(input string tag);
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    idle(3);
    check("rst_payload", payload, 32'h0);
    check("rst_pv", {31'd0, payload_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_crc", {24'd0, crc_err_count}, 32'd0);
    check("rst_tmo", {24'd0, timeout_err_count}, 32'd0);
    reset = 1'b0;
    idle(2);

    // 1: good frame
    send_frame(32'h01020304, 8'h04, 1'b1);
    expect_drained("t1_commit");
    check("t1_payload", payload, 32'h01020304);
    check("t1_crc", {24'd0, crc_err_count}, 32'd0);
    check("t1_tmo", {24'd0, timeout_err_count}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // 2: bad checksum, then saturation
    send_frame(32'h01020304, 8'hFF, 1'b0);
    idle(2);
    check("t2_crc1", {24'd0, crc_err_count}, 32'd1);
    check("t2_payload_kept", payload, 32'h01020304);
    for (int i = 0; i < 300; i++) send_frame(32'h01020304, 8'hFF, 1'b0);
    idle(2);
    check("t2_crc_sat", {24'd0, crc_err_count}, 32'd255);
    check("t2_payload_kept2", payload, 32'h01020304);

    // 3: junk before sync is ignored
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("t3_hunt_busy", {31'd0, busy}, 32'd0);
    send_frame(32'hDEADBEEF, 8'h22, 1'b1);
    expect_drained("t3_commit");
    check("t3_payload", payload, 32'hDEADBEEF);

    // 4: inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(15);
    check("t4_busy_pre", {31'd0, busy}, 32'd1);
    idle(1);
    check("t4_tmo", {24'd0, timeout_err_count}, 32'd1);
    check("t4_busy_post", {31'd0, busy}, 32'd0);
    send_frame(32'h01020304, 8'h04, 1'b1);
    expect_drained("t4_commit_after_tmo");
    // byte on the last allowed cycle, in both payload and check phases
    exp_q.push_back(32'h01020304);
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(15);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    idle(15);
    send_byte(8'h04);
    expect_drained("t4_edge_commit");
    check("t4_tmo_unchanged", {24'd0, timeout_err_count}, 32'd1);

    // 5: sync byte as data
    send_frame(32'hA5000001, 8'hA4, 1'b1);
    expect_drained("t5_commit");
    check("t5_payload", payload, 32'hA5000001);

    // 6: reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    idle(1);
    check("t6_payload", payload, 32'h0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_crc", {24'd0, crc_err_count}, 32'd0);
    check("t6_tmo", {24'd0, timeout_err_count}, 32'd0);
    check("t6_pv", {31'd0, payload_valid}, 32'd0);
    reset = 1'b0;
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    idle(2);
    check("t6_no_commit", payload, 32'h0);
    send_frame(32'h01020304, 8'h04, 1'b1);
    expect_drained("t6_commit");
    check("t6_payload_final", payload, 32'h01020304);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
